// File: rtl/bip_pkg.sv
// bip_pkg: shared encodings for the BIP accumulator datapath
// Exports ALU op codes, accumulator source selects, flag bit indices,
// multiplier FSM states and a flag-vector builder.
package bip_pkg;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRA = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SA_IN   = 2'b00,
        SA_EXT  = 2'b01,
        SA_ALU  = 2'b10,
        SA_ZERO = 2'b11
    } sel_a_e;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    // bit 0 = busy, bit 1 = done, so both outputs come straight off flops
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b11
    } mul_state_e;

    function automatic logic [3:0] mk_flags(logic z, logic n, logic c, logic v);
        logic [3:0] f;
        f      = '0;
        f[F_Z] = z;
        f[F_N] = n;
        f[F_C] = c;
        f[F_V] = v;
        return f;
    endfunction
endpackage

// File: rtl/bip_datapath_p_if.sv
// bip_datapath_p_if: control-unit/memory bus of the accumulator datapath
// master (control unit) drives operand, selects, opcodes, start and in_data;
// slave (datapath) returns addr, out_data, flags, busy and done.
interface bip_datapath_p_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 11
);
    logic [OP_W-1:0]   operand;
    logic [1:0]        sel_a;
    logic              sel_b;
    logic              wr_acc;
    logic [2:0]        alu_op;
    logic              start;
    logic [DATA_W-1:0] in_data;
    logic [OP_W-1:0]   addr;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        flags;
    logic              busy;
    logic              done;

    modport master (
        output operand, sel_a, sel_b, wr_acc, alu_op, start, in_data,
        input  addr, out_data, flags, busy, done
    );

    modport slave (
        input  operand, sel_a, sel_b, wr_acc, alu_op, start, in_data,
        output addr, out_data, flags, busy, done
    );
endinterface

// File: rtl/bip_datapath_p_iter_mul.sv
// iter_mul: unsigned shift-add multiplier, one partial product per cycle
// Ports: clk, reset (async active-low), start, a, b in; busy, done (state bits),
// fin (last RUN cycle), product (value the running sum takes at the next edge;
// on the fin cycle this is the full 2*DATA_W-bit product) out.
module iter_mul
    import bip_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic                fin,
    output logic [2*DATA_W-1:0] product
);
    localparam int CW = $clog2(DATA_W);

    mul_state_e          state;
    logic [2*DATA_W-1:0] mcand;
    logic [2*DATA_W-1:0] psum;
    logic [DATA_W-1:0]   mplier;
    logic [CW-1:0]       cnt;

    // exposing the next sum lets the top capture the result on the edge entering DONE
    assign product = psum + (mplier[0] ? mcand : '0);
    assign fin     = state == S_RUN && cnt == CW'(DATA_W - 1);
    assign busy    = state[0];
    assign done    = state[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            mcand  <= '0;
            psum   <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state  <= S_RUN;
                    mcand  <= {{DATA_W{1'b0}}, a};
                    mplier <= b;
                    psum   <= '0;
                    cnt    <= '0;
                end
                S_RUN: begin
                    psum   <= product;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (fin) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/bip_datapath_p.sv
// bip_datapath_p: parametrised BIP accumulator datapath with flags and iterative multiply
// Ports: clk, reset (async active-low), bus (bip_datapath_p_if.slave):
// operand/selects/opcode/start/in_data in; addr, out_data (acc), flags {Z,N,C,V},
// busy and done out. DATA_W must be >= OP_W.
module bip_datapath_p
    import bip_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 11
) (
    input logic               clk,
    input logic               reset,
    bip_datapath_p_if.slave   bus
);
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   ext;
    logic [DATA_W-1:0]   b;
    logic [DATA_W-1:0]   res;
    logic [DATA_W-1:0]   acc_nxt;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [3:0]          flags;
    logic                c;
    logic                v;
    logic                mul_go;
    logic                mul_busy;
    logic                mul_done;
    logic                mul_fin;
    logic [2*DATA_W-1:0] product;

    assign ext          = DATA_W'($signed(bus.operand));
    assign b            = bus.sel_b ? ext : bus.in_data;
    assign mul_go       = bus.start && bus.alu_op == OP_MUL;
    assign bus.addr     = bus.operand;
    assign bus.out_data = acc;
    assign bus.flags    = flags;
    assign bus.busy     = mul_busy;
    assign bus.done     = mul_done;

    always_comb begin
        sum  = {1'b0, acc} + {1'b0, b};
        diff = {1'b0, acc} - {1'b0, b};
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                res = sum[DATA_W-1:0];
                c   = sum[DATA_W];
                v   = acc[DATA_W-1] == b[DATA_W-1] && res[DATA_W-1] != acc[DATA_W-1];
            end
            OP_SUB: begin
                res = diff[DATA_W-1:0];
                c   = diff[DATA_W];
                v   = acc[DATA_W-1] != b[DATA_W-1] && res[DATA_W-1] != acc[DATA_W-1];
            end
            OP_AND: res = acc & b;
            OP_OR:  res = acc | b;
            OP_XOR: res = acc ^ b;
            OP_SLL: begin
                res = acc << 1;
                c   = acc[DATA_W-1];
            end
            OP_SRA: begin
                res = {acc[DATA_W-1], acc[DATA_W-1:1]};
                c   = acc[0];
            end
            default: res = '0;
        endcase
    end

    assign acc_nxt = bus.sel_a == SA_IN  ? bus.in_data :
                     bus.sel_a == SA_EXT ? ext :
                     bus.sel_a == SA_ALU ? res : '0;

    iter_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_go),
        .a       (acc),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .fin     (mul_fin),
        .product (product)
    );

    // a start in IDLE takes priority over wr_acc; nothing writes acc while busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            flags <= '0;
        end else if (mul_fin) begin
            acc   <= product[DATA_W-1:0];
            flags <= mk_flags(product[DATA_W-1:0] == '0, product[DATA_W-1],
                              |product[2*DATA_W-1:DATA_W], 1'b0);
        end else if (!mul_busy && !mul_go && bus.wr_acc) begin
            acc <= acc_nxt;
            if (bus.sel_a == SA_ALU) flags <= mk_flags(res == '0, res[DATA_W-1], c, v);
        end
    end
endmodule

// File: tb/tb_bip_datapath_p.sv
// tb_bip_datapath_p: table-driven and scoreboard bench for bip_datapath_p
module tb_bip_datapath_p;
    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bip_datapath_p_if #(.DATA_W(16), .OP_W(11)) bus ();

    bip_datapath_p #(.DATA_W(16), .OP_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sa;
        logic        sb;
        logic [2:0]  op;
        logic [10:0] opnd;
        logic [15:0] din;
        logic [15:0] e_acc;
        logic [3:0]  e_fl;
    } vec_t;

    typedef struct {
        logic [15:0] acc;
        logic [3:0]  fl;
    } exp_t;

    vec_t vecs[17];
    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic wr, input logic [1:0] sa, input logic sb, input logic [2:0] op,
                         input logic [10:0] opnd, input logic [15:0] din, input logic st);
        bus.wr_acc  = wr;
        bus.sel_a   = sa;
        bus.sel_b   = sb;
        bus.alu_op  = op;
        bus.operand = opnd;
        bus.in_data = din;
        bus.start   = st;
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_acc"}, 32'(bus.out_data), 32'(e.acc));
            chk({name, "_flags"}, 32'(bus.flags), 32'(e.fl));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                           input bit noise, input logic [15:0] e_acc, input logic [3:0] e_fl);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at = 0;
        drive(1'b1, 2'b00, 1'b0, 3'd0, 11'h0, a, 1'b0);
        tick();
        chk({name, "_load"}, 32'(bus.out_data), 32'(a));
        drive(1'b0, 2'b00, 1'b0, 3'd7, 11'h0, b, 1'b1);
        sb_q.push_back('{e_acc, e_fl});
        tick();
        drive(1'b0, 2'b00, 1'b0, 3'd7, 11'h0, 16'h0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = i;
                check_pop(name);
            end
            if (noise && i >= 3 && i <= 10)
                drive(1'b1, 2'(i), 1'b0, 3'd7, 11'($urandom), 16'($urandom), 1'b1);
            else
                drive(1'b0, 2'b00, 1'b0, 3'd7, 11'h0, 16'h0, 1'b0);
            tick();
        end
        if (sb_q.size() != 0) begin
            chk({name, "_no_done"}, 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
        chk({name, "_done_cycle"}, 32'(done_at), 32'd17);
        chk({name, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({name, "_acc_hold"}, 32'(bus.out_data), 32'(e_acc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 2'b01, 1'b0, 3'd0, 11'h7FF, 16'h0000, 16'hFFFF, 4'b0000};
        vecs[1]  = '{1'b1, 2'b10, 1'b1, 3'd0, 11'h001, 16'h0000, 16'h0000, 4'b1010};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 3'd0, 11'h055, 16'h7FFF, 16'h7FFF, 4'b1010};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 3'd0, 11'h0AA, 16'h0001, 16'h8000, 4'b0101};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 3'd1, 11'h000, 16'h0001, 16'h7FFF, 4'b0001};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 3'd0, 11'h000, 16'h8002, 16'h8002, 4'b0001};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 3'd6, 11'h000, 16'h0000, 16'hC001, 4'b0100};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 3'd0, 11'h000, 16'h8001, 16'h8001, 4'b0100};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 3'd5, 11'h000, 16'h0000, 16'h0002, 4'b0010};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 3'd0, 11'h000, 16'h00F0, 16'h00F0, 4'b0010};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 3'd2, 11'h000, 16'h0F0F, 16'h0000, 4'b1000};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 3'd3, 11'h000, 16'h1234, 16'h1234, 4'b0000};
        vecs[12] = '{1'b1, 2'b10, 1'b1, 3'd4, 11'h7FF, 16'h0000, 16'hEDCB, 4'b0100};
        vecs[13] = '{1'b1, 2'b11, 1'b0, 3'd0, 11'h000, 16'h5555, 16'h0000, 4'b0100};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 3'd1, 11'h000, 16'h0001, 16'hFFFF, 4'b0110};
        vecs[15] = '{1'b0, 2'b11, 1'b0, 3'd0, 11'h123, 16'h0000, 16'hFFFF, 4'b0110};
        vecs[16] = '{1'b1, 2'b10, 1'b1, 3'd0, 11'h400, 16'h0000, 16'hFBFF, 4'b0110};

        drive(1'b0, 2'b00, 1'b0, 3'd0, 11'h321, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_out_data", 32'(bus.out_data), 32'h0);
        chk("reset_flags", 32'(bus.flags), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_addr", 32'(bus.addr), 32'h321);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].wr, vecs[i].sa, vecs[i].sb, vecs[i].op, vecs[i].opnd, vecs[i].din, 1'b0);
            sb_q.push_back('{vecs[i].e_acc, vecs[i].e_fl});
            #1 chk($sformatf("vec%0d_addr", i), 32'(bus.addr), 32'(vecs[i].opnd));
            tick();
            check_pop($sformatf("vec%0d", i));
        end

        run_mul("mul_300x200", 16'd300, 16'd200, 1'b0, 16'hEA60, 4'b0100);
        run_mul("mul_256x256", 16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b1010);

        drive(1'b1, 2'b00, 1'b0, 3'd0, 11'h0, 16'd7, 1'b0);
        tick();
        drive(1'b0, 2'b00, 1'b0, 3'd7, 11'h0, 16'd9, 1'b1);
        @(posedge clk);
        drive(1'b0, 2'b00, 1'b0, 3'd7, 11'h0, 16'd9, 1'b0);
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'h0);
        chk("async_rst_done", 32'(bus.done), 32'h0);
        chk("async_rst_acc", 32'(bus.out_data), 32'h0);
        chk("async_rst_flags", 32'(bus.flags), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_mul("mul_noise", 16'd3, 16'd5, 1'b1, 16'd15, 4'b0000);
        run_mul("mul_6x7", 16'd6, 16'd7, 1'b0, 16'd42, 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
